// File: rtl/lane_merge_2to1.sv
// Two-lane to one-stream merger: per-lane FIFOs drained by an arbiter into a registered output.
// Define LANE_MERGE_STRICT_PRIO_EN for fixed lane-1 priority instead of round-robin.
module lane_merge_2to1 #(
  parameter int n     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [n-1:0]  in1,
  input  logic          in1_valid,
  output logic          in1_ready,
  input  logic [n-1:0]  in2,
  input  logic          in2_valid,
  output logic          in2_ready,
  output logic [n-1:0]  out,
  output logic          out_lane,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   lvl1,
  output logic [AW:0]   lvl2
);

  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ZERO_LVL = {(AW+1){1'b0}};
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [n-1:0]  mem1_r [DEPTH];
  logic [n-1:0]  mem2_r [DEPTH];
  logic [AW-1:0] wr1_r, rd1_r, wr2_r, rd2_r;
  logic [AW:0]   lvl1_r, lvl2_r;
  logic [n-1:0]  out_r;
  logic          out_lane_r;
  logic          out_valid_r;

  logic push1_s, push2_s, pop1_s, pop2_s;
  logic ne1_s, ne2_s, may_load_s, load_s, grant2_s;
  logic [n-1:0] head_s;

  // Ready depends only on registered occupancy, never on the consumer side.
  assign in1_ready = (lvl1_r != FULL_LVL);
  assign in2_ready = (lvl2_r != FULL_LVL);
  assign lvl1      = lvl1_r;
  assign lvl2      = lvl2_r;
  assign out       = out_r;
  assign out_lane  = out_lane_r;
  assign out_valid = out_valid_r;

  assign push1_s    = in1_valid && in1_ready;
  assign push2_s    = in2_valid && in2_ready;
  assign ne1_s      = (lvl1_r != ZERO_LVL);
  assign ne2_s      = (lvl2_r != ZERO_LVL);
  assign may_load_s = !out_valid_r || out_ready;
  assign load_s     = may_load_s && (ne1_s || ne2_s);
  assign pop1_s     = load_s && !grant2_s;
  assign pop2_s     = load_s && grant2_s;

`ifdef LANE_MERGE_STRICT_PRIO_EN
  // Grant selection: lane 1 always wins when it has data.
  always_comb begin
    grant2_s = 1'b0;
    if (ne1_s) begin
      grant2_s = 1'b0;
    end else if (ne2_s) begin
      grant2_s = 1'b1;
    end else begin
      grant2_s = 1'b0;
    end
  end
`else
  logic last_lane_r;

  // Grant selection: alternate away from the last served lane when both have data.
  always_comb begin
    grant2_s = 1'b0;
    if (ne1_s && ne2_s) begin
      grant2_s = !last_lane_r;
    end else if (ne2_s) begin
      grant2_s = 1'b1;
    end else begin
      grant2_s = 1'b0;
    end
  end

  // Round-robin history, advanced only when a word is actually loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_lane_r <= 1'b1;
    end else if (load_s) begin
      last_lane_r <= grant2_s;
    end else begin
      last_lane_r <= last_lane_r;
    end
  end
`endif

  // Head of the granted FIFO; only meaningful when load_s is set.
  always_comb begin
    head_s = mem1_r[rd1_r];
    if (grant2_s) begin
      head_s = mem2_r[rd2_r];
    end else begin
      head_s = mem1_r[rd1_r];
    end
  end

  // Storage arrays; stale contents are harmless because pointers and levels reset.
  always_ff @(posedge clk) begin
    if (push1_s) mem1_r[wr1_r] <= in1;
    if (push2_s) mem2_r[wr2_r] <= in2;
  end

  // Lane-1 pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr1_r  <= PTR_ZERO;
      rd1_r  <= PTR_ZERO;
      lvl1_r <= ZERO_LVL;
    end else begin
      if (push1_s) wr1_r <= wr1_r + PTR_ONE;
      if (pop1_s)  rd1_r <= rd1_r + PTR_ONE;
      case ({push1_s, pop1_s})
        2'b10:   lvl1_r <= lvl1_r + LVL_ONE;
        2'b01:   lvl1_r <= lvl1_r - LVL_ONE;
        default: lvl1_r <= lvl1_r;
      endcase
    end
  end

  // Lane-2 pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr2_r  <= PTR_ZERO;
      rd2_r  <= PTR_ZERO;
      lvl2_r <= ZERO_LVL;
    end else begin
      if (push2_s) wr2_r <= wr2_r + PTR_ONE;
      if (pop2_s)  rd2_r <= rd2_r + PTR_ONE;
      case ({push2_s, pop2_s})
        2'b10:   lvl2_r <= lvl2_r + LVL_ONE;
        2'b01:   lvl2_r <= lvl2_r - LVL_ONE;
        default: lvl2_r <= lvl2_r;
      endcase
    end
  end

  // Output register: load from the granted FIFO, or clear when nothing is available.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r       <= {n{1'b0}};
      out_lane_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      out_r       <= head_s;
      out_lane_r  <= grant2_s;
      out_valid_r <= 1'b1;
    end else if (may_load_s) begin
      out_r       <= {n{1'b0}};
      out_lane_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_r       <= out_r;
      out_lane_r  <= out_lane_r;
      out_valid_r <= out_valid_r;
    end
  end

endmodule
